// File: rtl/intcon_pkg.sv
// intcon_pkg: INTCON bit positions and reset value shared by the interrupt controller.
package intcon_pkg;
  localparam int GIE_B  = 7;
  localparam int EEIE_B = 6;
  localparam int T0IE_B = 5;
  localparam int INTE_B = 4;
  localparam int RBIE_B = 3;
  localparam int T0IF_B = 2;
  localparam int INTF_B = 1;
  localparam int RBIF_B = 0;
  localparam logic [7:0] INTCON_RST = 8'h00;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: parameterized-width two-flop synchronizer with synchronous active-low reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] s1_q, s2_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end
  assign q_o = s2_q;
endmodule

// File: rtl/intcon_ctrl.sv
// intcon_ctrl: INTCON register with flag capture, INT/RB edge detect, GIE arbitration, irq and wake.
module intcon_ctrl
  import intcon_pkg::*;
(
  input  logic       oscIn,
  input  logic       reset,
  input  logic       t0if,
  input  logic       rb0_int,
  input  logic       intedg,
  input  logic [3:0] rb_in,
  input  logic [3:0] rb_tris,
  input  logic       rb_rd,
  input  logic       eeif,
  input  logic       intcon_we,
  input  logic [7:0] intcon_wdata,
  input  logic       int_ack,
  input  logic       retfie,
  output logic [7:0] intcon_q,
  output logic       irq,
  output logic       wake
);
  logic       int_sync, int_prev_q, int_edge, rb_chg, pend;
  logic [3:0] rb_sync, rb_latch_q, rb_latch_d;
  logic [7:0] intcon_d, base;
  logic       irq_q, irq_d, wake_q, wake_d;

  sync_2ff #(.W(1)) u_int_sync (.clk_i(oscIn), .rst_ni(reset), .d_i(rb0_int), .q_o(int_sync));
  sync_2ff #(.W(4)) u_rb_sync  (.clk_i(oscIn), .rst_ni(reset), .d_i(rb_in),   .q_o(rb_sync));

  // Hardware sets are OR-ed over the written value so a set always beats a same-cycle clear.
  always_comb begin
    int_edge   = intedg ? (int_sync & ~int_prev_q) : (~int_sync & int_prev_q);
    rb_chg     = |((rb_sync ^ rb_latch_q) & rb_tris);
    rb_latch_d = rb_rd ? rb_sync : rb_latch_q;
    base       = intcon_we ? intcon_wdata : intcon_q;
    intcon_d   = base | {5'b0, t0if, int_edge, rb_chg};
    intcon_d[GIE_B] = int_ack ? 1'b0 : retfie ? 1'b1 : base[GIE_B];
    pend   = (intcon_q[T0IE_B] & intcon_q[T0IF_B]) | (intcon_q[INTE_B] & intcon_q[INTF_B]) |
             (intcon_q[RBIE_B] & intcon_q[RBIF_B]) | (intcon_q[EEIE_B] & eeif);
    irq_d  = intcon_q[GIE_B] & pend & ~int_ack;
    wake_d = pend;
  end

  always_ff @(posedge oscIn) begin
    if (!reset) begin
      intcon_q   <= INTCON_RST;
      int_prev_q <= 1'b0;
      rb_latch_q <= 4'h0;
      irq_q      <= 1'b0;
      wake_q     <= 1'b0;
    end else begin
      intcon_q   <= intcon_d;
      int_prev_q <= int_sync;
      rb_latch_q <= rb_latch_d;
      irq_q      <= irq_d;
      wake_q     <= wake_d;
    end
  end

  assign irq  = irq_q;
  assign wake = wake_q;
endmodule

// File: doc/intcon_ctrl.md
INTCON_CTRL -- requirements
Module: intcon_ctrl

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
REQ-002 oscIn  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 t0if  in  1  one-cycle TMR0 overflow pulse from tmr0.
REQ-005 rb0_int  in  1  external INT pin, asynchronous.
REQ-006 intedg  in  1  OPTION bit 6: 1 = rising-edge INT, 0 = falling-edge INT.
REQ-007 rb_in  in  4  RB7:RB4 pins, asynchronous.
REQ-008 rb_tris  in  4  1 = pin is input; only input pins take part in change detect.
REQ-009 rb_rd  in  1  CPU PORTB read strobe; loads the RB compare latch.
REQ-010 eeif  in  1  EE-write-complete flag level (owned by EECON1).
REQ-011 intcon_we  in  1  CPU write strobe for INTCON.
REQ-012 intcon_wdata  in  8  INTCON write data.
REQ-013 int_ack  in  1  CPU vectoring pulse; clears GIE.
REQ-014 retfie  in  1  RETFIE pulse; sets GIE.
REQ-015 intcon_q  out  8  INTCON contents: bit 7 GIE, 6 EEIE, 5 T0IE, 4 INTE, 3 RBIE, 2 T0IF, 1 INTF, 0 RBIF.
REQ-016 irq  out  1  registered interrupt request to CPU.
REQ-017 wake  out  1  registered SLEEP wake-up request, independent of GIE.

Function
REQ-018 INTCON SHALL be written with intcon_wdata on a rising edge where intcon_we=1, subject to REQ-019 to REQ-021.
REQ-019 When a hardware set and a software write to the same flag occur in the same cycle, the flag SHALL end at 1.
REQ-020 GIE SHALL be updated with priority int_ack (->0) > retfie (->1) > intcon_we (-> wdata[7]).
REQ-021 T0IF SHALL be set on the edge after a t0if pulse; a held-high t0if keeps T0IF set.
REQ-022 rb0_int SHALL pass through a 2-flop synchronizer followed by a previous-value flop.
REQ-023 INTF SHALL be set when synchronized and previous values show the edge selected by intedg; a pin change meeting setup before edge k sets INTF after edge k+2.
REQ-024 A change of intedg alone SHALL NOT set INTF.
REQ-025 rb_in SHALL be 2-flop synchronized; rb_rd SHALL load the compare latch with the synchronized value.
REQ-026 RBIF SHALL be set every cycle in which any bit with rb_tris=1 differs between the synchronized RB value and the compare latch; a CPU clear of RBIF has no effect while the mismatch persists.
REQ-027 Pending condition p = (T0IE&T0IF)|(INTE&INTF)|(RBIE&RBIF)|(EEIE&eeif), evaluated from current register values.
REQ-028 irq SHALL be registered as GIE&p, so irq rises one cycle after GIE&p becomes true.
REQ-029 irq SHALL fall on the edge after int_ack.
REQ-030 wake SHALL be registered as p, regardless of GIE.
REQ-031 Flags SHALL set whether or not the matching enable bit is set.
REQ-032 Flags SHALL clear only by a CPU write.

Reset
REQ-033 While reset=0 at a rising edge: INTCON=8'h00, irq=0, wake=0, synchronizer and previous-value flops=0, compare latch=4'h0.
REQ-034 Reset SHALL override every concurrent event, including a t0if pulse, a write, int_ack and retfie.
REQ-035 After reset, a pin held high SHALL NOT produce a falling edge; with intedg=1 it SHALL produce one rising edge, so INTF=1.

Structure
REQ-036 Package intcon_pkg SHALL hold the INTCON bit-index constants and the 8'h00 reset value.
REQ-037 Sub-module sync_2ff SHALL provide a parameterized-width 2-flop synchronizer, instantiated for rb0_int (width 1) and rb_in (width 4).
REQ-038 Edge detect, flags, GIE arbitration, irq and wake SHALL live in intcon_ctrl.

Verification
REQ-039 Overflow: INTCON=8'hA0, pulse t0if -> T0IF=1 next edge, irq=1 one edge later, intcon_q=8'hA4; int_ack -> GIE=0, irq=0 next edge.
REQ-040 INT edge: intedg=0, INTE=1, GIE=1, drive rb0_int 1->0 -> INTF=1 at edge k+2; drive 0->1 -> no set; toggle intedg with pin static -> INTF unchanged.
REQ-041 RB change: rb_tris=4'hF, rb_rd with rb_in=4'h5, then rb_in=4'h7 -> RBIF=1; write RBIF=0 -> stays 1; rb_rd -> next write clears it; change a bit with tris=0 -> no set.
REQ-042 Collision: t0if pulse in the same cycle as a write of 8'h00 -> T0IF=1; int_ack with retfie in the same cycle -> GIE=0.
REQ-043 Wake: GIE=0, EEIE=1, eeif=1 -> wake=1, irq=0.
REQ-044 Mid-operation reset: reset=0 while irq=1 and all flags set -> next edge all outputs 0, intcon_q=8'h00.
